// File: rtl/mwave_pkg.sv
// mwave_pkg: shared state encoding, BCD constants and keypad decode for microwave_sequencer.
package mwave_pkg;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] MAX_TENS = 4'd5;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
    localparam logic [3*DIGIT_W-1:0] QUICK_SECS = 12'h030;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        COOKING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;
    function automatic logic [DIGIT_W-1:0] key_digit(input logic [9:0] k);
        logic [DIGIT_W-1:0] d;
        d = '0;
        for (int i = 0; i < 10; i++) if (k[i]) d = DIGIT_W'(i);
        return d;
    endfunction
endpackage

// File: rtl/mmss_down_counter.sv
// mmss_down_counter: three BCD digits (m:ss) with load, shift-in, decrement, add-30 and zero flags.
module mmss_down_counter
    import mwave_pkg::*;
(
    input  logic               clk,
    input  logic               clearn,
    input  logic               i_clr,
    input  logic               i_load_qs,
    input  logic               i_shift,
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic               i_dec,
    input  logic               i_add30,
    output logic [DIGIT_W-1:0] o_min,
    output logic [DIGIT_W-1:0] o_tens,
    output logic [DIGIT_W-1:0] o_secs,
    output logic               o_zero,
    output logic               o_last
);
    logic [DIGIT_W-1:0] r_min, r_tens, r_secs;
    logic [DIGIT_W-1:0] w_dec_min, w_dec_tens, w_dec_secs, w_sum_tens, w_add_tens;
    logic [DIGIT_W:0]   w_add_min;
    logic               w_carry, w_sat;

    // Entered tens above 5 simply count down; only a borrow reloads tens with 5.
    always_comb begin
        w_dec_secs = (r_secs == '0) ? MAX_DIGIT : r_secs - 4'd1;
        w_dec_tens = (r_secs != '0) ? r_tens : (r_tens == '0) ? MAX_TENS : r_tens - 4'd1;
        w_dec_min  = (r_secs == '0 && r_tens == '0) ? r_min - 4'd1 : r_min;
        w_sum_tens = r_tens + QUICK_SECS[7:4];
        w_carry    = w_sum_tens > MAX_TENS;
        w_add_tens = w_carry ? w_sum_tens - (MAX_TENS + 4'd1) : w_sum_tens;
        w_add_min  = {1'b0, r_min} + {{DIGIT_W{1'b0}}, w_carry};
        w_sat      = w_add_min > {1'b0, MAX_DIGIT};
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            {r_min, r_tens, r_secs} <= '0;
        end else if (i_clr) begin
            {r_min, r_tens, r_secs} <= '0;
        end else if (i_load_qs) begin
            {r_min, r_tens, r_secs} <= QUICK_SECS;
        end else if (i_shift) begin
            {r_min, r_tens, r_secs} <= {r_tens, r_secs, i_digit};
        end else if (i_dec && !o_zero) begin
            {r_min, r_tens, r_secs} <= {w_dec_min, w_dec_tens, w_dec_secs};
        end else if (i_add30) begin
            {r_min, r_tens, r_secs} <= w_sat ? {MAX_DIGIT, MAX_TENS, MAX_DIGIT}
                                             : {w_add_min[DIGIT_W-1:0], w_add_tens, r_secs};
        end
    end

    assign o_min  = r_min;
    assign o_tens = r_tens;
    assign o_secs = r_secs;
    assign o_zero = {r_min, r_tens, r_secs} == 12'h000;
    assign o_last = {r_min, r_tens, r_secs} == 12'h001;
endmodule

// File: rtl/microwave_sequencer.sv
// microwave_sequencer: keypad/button sequencer with 1 s prescaler, mm:ss countdown and done beep.
// Define MWAVE_QUICK_START_EN for start-in-IDLE (0:30) and start-while-cooking (+30 s).
module microwave_sequencer
    import mwave_pkg::*;
#(
    parameter int CLK_DIV   = 50_000_000,
    parameter int BEEP_SECS = 3
) (
    input  logic               clk,
    input  logic               clearn,
    input  logic [9:0]         keypad,
    input  logic               startn,
    input  logic               stopn,
    input  logic               canceln,
    input  logic               door_closed,
    output logic [DIGIT_W-1:0] minutes,
    output logic [DIGIT_W-1:0] tens_secs,
    output logic [DIGIT_W-1:0] secs,
    output logic               mag_on,
    output logic               beep,
    output logic [2:0]         state
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;

    state_t          r_state, w_nxt;
    logic [PW-1:0]   r_presc;
    logic [BW-1:0]   r_beep_cnt;
    logic            r_mag, r_beep;
    logic            r_startn_q, r_stopn_q, r_canceln_q;
    logic [9:0]      r_key_q;
    logic            w_start, w_stop, w_cancel, w_key, w_tick, w_cook_entry;
    logic            w_clr, w_shift, w_dec, w_add30, w_load_qs, w_qs_load, w_qs_add;
    logic            w_zero, w_last;

    assign w_start  = r_startn_q & ~startn;
    assign w_stop   = r_stopn_q & ~stopn;
    assign w_cancel = r_canceln_q & ~canceln;
    assign w_key    = $onehot(keypad) && |(keypad & ~r_key_q);
    assign w_tick   = r_presc == PW'(CLK_DIV - 1);

`ifdef MWAVE_QUICK_START_EN
    assign w_qs_load = w_start && door_closed && r_state == IDLE;
    assign w_qs_add  = w_start && r_state == COOKING;
`else
    assign w_qs_load = 1'b0;
    assign w_qs_add  = 1'b0;
`endif

    // Priority chain: cancel, door open, stop, start, key, then timer ticks.
    always_comb begin
        w_nxt     = r_state;
        w_clr     = 1'b0;
        w_shift   = 1'b0;
        w_dec     = 1'b0;
        w_add30   = 1'b0;
        w_load_qs = 1'b0;
        if (w_cancel) begin
            w_nxt = IDLE;
            w_clr = 1'b1;
        end else if (r_state == COOKING && !door_closed) begin
            w_nxt = PAUSED;
        end else if (w_stop && r_state == COOKING) begin
            w_nxt = PAUSED;
        end else if (w_stop && r_state != IDLE) begin
            w_nxt = IDLE;
            w_clr = 1'b1;
        end else if (w_start && door_closed && !w_zero && (r_state == ENTRY || r_state == PAUSED)) begin
            w_nxt = COOKING;
        end else if (w_qs_load) begin
            w_load_qs = 1'b1;
            w_nxt     = COOKING;
        end else if (w_qs_add) begin
            w_add30 = 1'b1;
        end else if (w_key && (r_state == IDLE || r_state == ENTRY || r_state == DONE)) begin
            w_shift = 1'b1;
            w_nxt   = ENTRY;
        end else if (r_state == COOKING && w_tick) begin
            w_dec = 1'b1;
            w_nxt = w_last ? DONE : COOKING;
        end else if (r_state == DONE && w_tick && r_beep_cnt == BW'(BEEP_SECS - 1)) begin
            w_nxt = IDLE;
        end
    end

    assign w_cook_entry = r_state != COOKING && w_nxt == COOKING;

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            r_state     <= IDLE;
            r_presc     <= '0;
            r_beep_cnt  <= '0;
            r_mag       <= 1'b0;
            r_beep      <= 1'b0;
            r_startn_q  <= 1'b1;
            r_stopn_q   <= 1'b1;
            r_canceln_q <= 1'b1;
            r_key_q     <= '0;
        end else begin
            r_state     <= w_nxt;
            r_mag       <= w_nxt == COOKING;
            r_beep      <= w_nxt == DONE;
            r_startn_q  <= startn;
            r_stopn_q   <= stopn;
            r_canceln_q <= canceln;
            r_key_q     <= keypad;
            r_presc     <= (w_cook_entry || w_tick || !(w_nxt == COOKING || w_nxt == DONE))
                           ? '0 : r_presc + PW'(1);
            r_beep_cnt  <= (r_state != DONE || w_nxt != DONE) ? '0 : r_beep_cnt + BW'(w_tick);
        end
    end

    mmss_down_counter u_cnt (
        .clk       (clk),
        .clearn    (clearn),
        .i_clr     (w_clr),
        .i_load_qs (w_load_qs),
        .i_shift   (w_shift),
        .i_digit   (key_digit(keypad)),
        .i_dec     (w_dec),
        .i_add30   (w_add30),
        .o_min     (minutes),
        .o_tens    (tens_secs),
        .o_secs    (secs),
        .o_zero    (w_zero),
        .o_last    (w_last)
    );

    assign mag_on = r_mag;
    assign beep   = r_beep;
    assign state  = r_state;
endmodule

// File: tb/tb_microwave_sequencer.sv
// tb_microwave_sequencer: directed stimulus with a queued scoreboard checked by a negedge monitor.
module tb_microwave_sequencer;
    localparam logic [2:0] S_IDLE = 3'd0, S_ENTRY = 3'd1, S_COOK = 3'd2, S_PAUSE = 3'd3, S_DONE = 3'd4;

    logic       clk = 1'b0, clearn = 1'b0, startn = 1'b1, stopn = 1'b1, canceln = 1'b1, door_closed = 1'b1;
    logic [9:0] keypad = '0;
    logic [3:0] minutes, tens_secs, secs;
    logic       mag_on, beep;
    logic [2:0] state;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic [3:0] m, t, s;
        logic       mg, bp;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0, errors = 0;

    microwave_sequencer #(.CLK_DIV(4), .BEEP_SECS(2)) dut (
        .clk         (clk),
        .clearn      (clearn),
        .keypad      (keypad),
        .startn      (startn),
        .stopn       (stopn),
        .canceln     (canceln),
        .door_closed (door_closed),
        .minutes     (minutes),
        .tens_secs   (tens_secs),
        .secs        (secs),
        .mag_on      (mag_on),
        .beep        (beep),
        .state       (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if ({state, minutes, tens_secs, secs, mag_on, beep} !== {e.st, e.m, e.t, e.s, e.mg, e.bp}) begin
                errors++;
                $display("FAIL %s: got st=%0d %0d:%0d%0d mag=%b beep=%b, expected st=%0d %0d:%0d%0d mag=%b beep=%b",
                         e.name, state, minutes, tens_secs, secs, mag_on, beep, e.st, e.m, e.t, e.s, e.mg, e.bp);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [2:0] st, input logic [3:0] m, t, s, input logic mg, bp);
        exp_t x;
        x.name = n; x.st = st; x.m = m; x.t = t; x.s = s; x.mg = mg; x.bp = bp;
        sb.push_back(x);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: monitor left %0d expectation(s) unchecked, expected 0", n, sb.size());
            sb.delete();
        end
    endtask

    task automatic btn(input logic s, p, c);
        @(posedge clk); #1;
        startn = ~s; stopn = ~p; canceln = ~c;
        @(posedge clk); #1;
        startn = 1'b1; stopn = 1'b1; canceln = 1'b1;
    endtask

    task automatic key(input int d);
        @(posedge clk); #1;
        keypad = '0;
        keypad[d] = 1'b1;
        @(posedge clk); #1;
        keypad = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        cyc(2);
        chk("reset", S_IDLE, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        clearn = 1'b1;
        // 1:30 full cook, done beep, back to idle
        key(1); key(3); key(0);
        chk("entry_130", S_ENTRY, 1, 3, 0, 0, 0);
        btn(1, 0, 0);
        chk("cook_130", S_COOK, 1, 3, 0, 1, 0);
        cyc(4);
        chk("tick_129", S_COOK, 1, 2, 9, 1, 0);
        cyc(355);
        chk("cook_001", S_COOK, 0, 0, 1, 1, 0);
        cyc(1);
        chk("done_130", S_DONE, 0, 0, 0, 0, 1);
        cyc(7);
        chk("beep_hold", S_DONE, 0, 0, 0, 0, 1);
        cyc(1);
        chk("beep_end", S_IDLE, 0, 0, 0, 0, 0);
        // 0:99 counted as-is
        key(0); key(9); key(9);
        chk("entry_099", S_ENTRY, 0, 9, 9, 0, 0);
        btn(1, 0, 0);
        chk("cook_099", S_COOK, 0, 9, 9, 1, 0);
        cyc(4);
        chk("tick_098", S_COOK, 0, 9, 8, 1, 0);
        cyc(32);
        chk("tick_090", S_COOK, 0, 9, 0, 1, 0);
        cyc(4);
        chk("tick_089", S_COOK, 0, 8, 9, 1, 0);
        cyc(355);
        chk("cook99_001", S_COOK, 0, 0, 1, 1, 0);
        cyc(1);
        chk("done_099", S_DONE, 0, 0, 0, 0, 1);
        btn(0, 0, 1);
        chk("cancel_done", S_IDLE, 0, 0, 0, 0, 0);
        // door open pause and resume
        key(9);
        btn(1, 0, 0);
        chk("cook_009", S_COOK, 0, 0, 9, 1, 0);
        cyc(16);
        chk("tick_005", S_COOK, 0, 0, 5, 1, 0);
        door_closed = 1'b0;
        cyc(1);
        chk("door_pause", S_PAUSE, 0, 0, 5, 0, 0);
        btn(1, 0, 0);
        chk("start_door_open", S_PAUSE, 0, 0, 5, 0, 0);
        door_closed = 1'b1;
        cyc(1);
        chk("door_shut_paused", S_PAUSE, 0, 0, 5, 0, 0);
        btn(1, 0, 0);
        chk("resume", S_COOK, 0, 0, 5, 1, 0);
        cyc(4);
        chk("resume_tick", S_COOK, 0, 0, 4, 1, 0);
        // simultaneous buttons, stop twice
        btn(1, 1, 1);
        chk("all_three", S_IDLE, 0, 0, 0, 0, 0);
        key(5);
        btn(1, 0, 0);
        chk("cook_005", S_COOK, 0, 0, 5, 1, 0);
        btn(0, 1, 0);
        chk("stop_pause", S_PAUSE, 0, 0, 5, 0, 0);
        btn(0, 1, 0);
        chk("stop_idle", S_IDLE, 0, 0, 0, 0, 0);
        // quick start
        btn(1, 0, 0);
`ifdef MWAVE_QUICK_START_EN
        chk("qs_idle", S_COOK, 0, 3, 0, 1, 0);
        btn(0, 0, 1);
        chk("qs_cancel", S_IDLE, 0, 0, 0, 0, 0);
`else
        chk("qs_idle_ignored", S_IDLE, 0, 0, 0, 0, 0);
`endif
        key(9); key(4); key(5);
        btn(1, 0, 0);
        chk("cook_945", S_COOK, 9, 4, 5, 1, 0);
        btn(1, 0, 0);
`ifdef MWAVE_QUICK_START_EN
        chk("qs_add_sat", S_COOK, 9, 5, 9, 1, 0);
`else
        chk("qs_add_ignored", S_COOK, 9, 4, 5, 1, 0);
`endif
        btn(0, 0, 1);
        chk("cancel_cook", S_IDLE, 0, 0, 0, 0, 0);
        // keypad edge rules
        @(posedge clk); #1;
        keypad = 10'b00_0000_0011;
        @(posedge clk); #1;
        keypad = '0;
        chk("key_multi", S_IDLE, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        keypad[7] = 1'b1;
        cyc(3);
        keypad = '0;
        chk("key_held", S_ENTRY, 0, 0, 7, 0, 0);
        // asynchronous reset mid-cook
        btn(1, 0, 0);
        chk("cook_007", S_COOK, 0, 0, 7, 1, 0);
        @(posedge clk); #1;
        clearn = 1'b0;
        chk("rst_async", S_IDLE, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        clearn = 1'b1;
        chk("rst_release", S_IDLE, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
